// File: rtl/b2a_pkg.sv
// ---------------------------------------------------------------------------
// b2a_pkg
//   Shared definitions for the masked share-conversion cores and their
//   on-chip checker.
//   - conv_mode_e : conversion direction (B2A = xor-in/add-out,
//                   A2B = add-in/xor-out)
//   - DELAY_CSA   : pipeline depth of the carry-save stage
//   - f_delay_ksa : pipeline depth of one Kogge-Stone adder of width k
//   - f_randnum   : fresh random bits consumed by one masked AND layer
// ---------------------------------------------------------------------------
package b2a_pkg;

   typedef enum logic {
      B2A = 1'b0,
      A2B = 1'b1
   } conv_mode_e;

   localparam int DELAY_CSA = 1;

   // log2(k) prefix levels plus the final sum register.
   function automatic int f_delay_ksa(input int k);
      int lg;
      lg = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < k) lg = i + 1;
      end
      return lg + 1;
   endfunction

   // One random word per share pair for each of the k bit positions.
   function automatic int f_randnum(input int k, input int n);
      return k * n * (n - 1) / 2;
   endfunction

endpackage

// File: rtl/vld_delay_line.sv
// ---------------------------------------------------------------------------
// vld_delay_line
//   Fixed-depth shift register with asynchronous reset to zero. Carries the
//   packed {vld, mode, ref} entry of each sample alongside the core under
//   check. Advances every cycle; no stall.
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, clears every stage
//   din    in   W   entry captured into stage 0
//   dout   out  W   stage DEPTH-1
// ---------------------------------------------------------------------------
module vld_delay_line #(
   parameter int W     = 34,
   parameter int DEPTH = 13
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] stage [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/masked_conv_checker.sv
// ---------------------------------------------------------------------------
// masked_conv_checker
//   On-chip scoreboard for masked share-conversion cores (SecB2A / SecA2B).
//   Folds the input shares into an unmasked reference, delays it by the core
//   latency, and compares it with the unmasked fold of the output shares.
//   Counts checks, value mismatches and valid-protocol faults, and captures
//   the first value mismatch. Self-test only; not in the secure datapath.
// Ports
//   clk, rst_n          clock / asynchronous active-low reset
//   clr                 synchronous clear of counters, sticky flag, capture
//   mode                0 = B2A check, 1 = A2B check, sampled with in_vld
//   in_vld, in_shares   core input sample (share i at [i*K_WIDTH +: K_WIDTH])
//   out_vld, out_shares core output sample
//   err_pulse           one-cycle pulse on any fault
//   sticky_err          held fault flag
//   check_cnt           completed comparisons (saturating)
//   mismatch_cnt        value mismatches (saturating)
//   proto_cnt           missing + unexpected out_vld (saturating)
//   cap_vld/exp/got     first value mismatch capture
// ---------------------------------------------------------------------------
module masked_conv_checker
   import b2a_pkg::*;
#(
   parameter int K_WIDTH  = 32,
   parameter int N_SHARES = 3,
   parameter int LATENCY  = DELAY_CSA + 2 * f_delay_ksa(K_WIDTH),
   parameter int CNT_W    = 16
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr,
   input  logic                          mode,
   input  logic                          in_vld,
   input  logic [K_WIDTH*N_SHARES-1:0]   in_shares,
   input  logic                          out_vld,
   input  logic [K_WIDTH*N_SHARES-1:0]   out_shares,
   output logic                          err_pulse,
   output logic                          sticky_err,
   output logic [CNT_W-1:0]              check_cnt,
   output logic [CNT_W-1:0]              mismatch_cnt,
   output logic [CNT_W-1:0]              proto_cnt,
   output logic                          cap_vld,
   output logic [K_WIDTH-1:0]            cap_exp,
   output logic [K_WIDTH-1:0]            cap_got
);

   localparam int PIPE_W = K_WIDTH + 2;

   function automatic logic [K_WIDTH-1:0] fold_xor(input logic [K_WIDTH*N_SHARES-1:0] s);
      logic [K_WIDTH-1:0] acc;
      acc = '0;
      for (int i = 0; i < N_SHARES; i++) acc = acc ^ s[i*K_WIDTH +: K_WIDTH];
      return acc;
   endfunction

   // Arithmetic fold is modulo 2^K_WIDTH: the accumulator width drops carries.
   function automatic logic [K_WIDTH-1:0] fold_add(input logic [K_WIDTH*N_SHARES-1:0] s);
      logic [K_WIDTH-1:0] acc;
      acc = '0;
      for (int i = 0; i < N_SHARES; i++) acc = acc + s[i*K_WIDTH +: K_WIDTH];
      return acc;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   // ---- stage 0 entry: reference computed from the input shares ----
   logic [K_WIDTH-1:0] ref_p0;
   logic [PIPE_W-1:0]  ent_p0;

   always_comb begin
      ref_p0 = (conv_mode_e'(mode) == B2A) ? fold_xor(in_shares) : fold_add(in_shares);
      ent_p0 = in_vld ? {1'b1, mode, ref_p0} : '0;
   end

   logic [PIPE_W-1:0] ent_pl;

   vld_delay_line #(
      .W     (PIPE_W),
      .DEPTH (LATENCY)
   ) u_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (ent_p0),
      .dout  (ent_pl)
   );

   // ---- stage LATENCY-1: classification against the core output ----
   logic               exp_vld_pl;
   conv_mode_e         exp_mode_pl;
   logic [K_WIDTH-1:0] exp_pl;
   logic [K_WIDTH-1:0] got_pl;
   logic               is_check;
   logic               is_mis;
   logic               is_proto;

   always_comb begin
      exp_vld_pl  = ent_pl[PIPE_W-1];
      exp_mode_pl = conv_mode_e'(ent_pl[PIPE_W-2]);
      exp_pl      = ent_pl[K_WIDTH-1:0];
      // The output fold is the opposite domain of the input fold.
      got_pl      = (exp_mode_pl == B2A) ? fold_add(out_shares) : fold_xor(out_shares);
      is_check    = exp_vld_pl & out_vld;
      is_mis      = is_check & (got_pl != exp_pl);
      is_proto    = exp_vld_pl ^ out_vld;
   end

   // ---- result registers: visible one cycle after classification ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_pulse    <= 1'b0;
         sticky_err   <= 1'b0;
         check_cnt    <= '0;
         mismatch_cnt <= '0;
         proto_cnt    <= '0;
         cap_vld      <= 1'b0;
         cap_exp      <= '0;
         cap_got      <= '0;
      end else begin
         // The pulse reports the event even when clr wipes the bookkeeping.
         err_pulse <= is_mis | is_proto;
         if (clr) begin
            sticky_err   <= 1'b0;
            check_cnt    <= '0;
            mismatch_cnt <= '0;
            proto_cnt    <= '0;
            cap_vld      <= 1'b0;
            cap_exp      <= '0;
            cap_got      <= '0;
         end else begin
            if (is_check) check_cnt    <= sat_inc(check_cnt);
            if (is_mis)   mismatch_cnt <= sat_inc(mismatch_cnt);
            if (is_proto) proto_cnt    <= sat_inc(proto_cnt);
            if (is_mis | is_proto) sticky_err <= 1'b1;
            if (is_mis && !cap_vld) begin
               cap_vld <= 1'b1;
               cap_exp <= exp_pl;
               cap_got <= got_pl;
            end
         end
      end
   end

endmodule

// File: tb/tb_masked_conv_checker.sv
// ---------------------------------------------------------------------------
// tb_masked_conv_checker
//   Directed bench for masked_conv_checker. A 16-bit-counter instance and a
//   4-bit-counter instance share the same stimulus.
// ---------------------------------------------------------------------------
module tb_masked_conv_checker;

   localparam int K   = 32;
   localparam int N   = 3;
   localparam int LAT = b2a_pkg::DELAY_CSA + 2 * b2a_pkg::f_delay_ksa(K);

   logic           clk = 1'b0;
   logic           rst_n;
   logic           clr;
   logic           mode;
   logic           in_vld;
   logic [K*N-1:0] in_shares;
   logic           out_vld;
   logic [K*N-1:0] out_shares;

   logic           err_pulse, sticky_err, cap_vld;
   logic [15:0]    check_cnt, mismatch_cnt, proto_cnt;
   logic [K-1:0]   cap_exp, cap_got;

   logic           err_pulse4, sticky_err4, cap_vld4;
   logic [3:0]     check_cnt4, mismatch_cnt4, proto_cnt4;
   logic [K-1:0]   cap_exp4, cap_got4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   masked_conv_checker #(.K_WIDTH(K), .N_SHARES(N), .LATENCY(LAT), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode),
      .in_vld(in_vld), .in_shares(in_shares), .out_vld(out_vld), .out_shares(out_shares),
      .err_pulse(err_pulse), .sticky_err(sticky_err), .check_cnt(check_cnt),
      .mismatch_cnt(mismatch_cnt), .proto_cnt(proto_cnt),
      .cap_vld(cap_vld), .cap_exp(cap_exp), .cap_got(cap_got)
   );

   masked_conv_checker #(.K_WIDTH(K), .N_SHARES(N), .LATENCY(LAT), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode),
      .in_vld(in_vld), .in_shares(in_shares), .out_vld(out_vld), .out_shares(out_shares),
      .err_pulse(err_pulse4), .sticky_err(sticky_err4), .check_cnt(check_cnt4),
      .mismatch_cnt(mismatch_cnt4), .proto_cnt(proto_cnt4),
      .cap_vld(cap_vld4), .cap_exp(cap_exp4), .cap_got(cap_got4)
   );

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input logic m, input logic [K-1:0] s0, input logic [K-1:0] s1,
                       input logic [K-1:0] s2);
      mode      = m;
      in_shares = {s2, s1, s0};
      in_vld    = 1'b1;
      tick();
      in_vld    = 1'b0;
   endtask

   task automatic respond(input logic [K-1:0] o0, input logic [K-1:0] o1, input logic [K-1:0] o2);
      out_shares = {o2, o1, o0};
      out_vld    = 1'b1;
      tick();
      out_vld    = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; mode = 1'b0; in_vld = 1'b0; out_vld = 1'b0;
      in_shares = '0; out_shares = '0;
      idle(2);
      checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL rst_err_pulse got %0b exp 0", err_pulse); end
      checks++; if (sticky_err !== 1'b0) begin errors++; $display("FAIL rst_sticky got %0b exp 0", sticky_err); end
      checks++; if ({check_cnt, mismatch_cnt, proto_cnt} !== 48'd0) begin errors++; $display("FAIL rst_counts got %h exp 0", {check_cnt, mismatch_cnt, proto_cnt}); end
      checks++; if ({cap_vld, cap_exp, cap_got} !== 65'd0) begin errors++; $display("FAIL rst_capture got %h exp 0", {cap_vld, cap_exp, cap_got}); end
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_b2a_pass();
      send(1'b0, 32'd1, 32'd2, 32'd4);
      idle(LAT - 1);
      respond(32'd5, 32'd1, 32'd1);
      checks++; if (check_cnt !== 16'd1) begin errors++; $display("FAIL b2a_pass_check_cnt got %0d exp 1", check_cnt); end
      checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL b2a_pass_err_pulse got %0b exp 0", err_pulse); end
      checks++; if (mismatch_cnt !== 16'd0 || proto_cnt !== 16'd0) begin errors++; $display("FAIL b2a_pass_faults got %0d/%0d exp 0/0", mismatch_cnt, proto_cnt); end
   endtask

   task automatic test_b2a_mismatch();
      send(1'b0, 32'd1, 32'd2, 32'd4);
      idle(LAT - 1);
      respond(32'd5, 32'd1, 32'd2);
      checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL mis_err_pulse got %0b exp 1", err_pulse); end
      checks++; if (mismatch_cnt !== 16'd1) begin errors++; $display("FAIL mis_cnt got %0d exp 1", mismatch_cnt); end
      checks++; if (check_cnt !== 16'd2) begin errors++; $display("FAIL mis_check_cnt got %0d exp 2", check_cnt); end
      checks++; if (cap_vld !== 1'b1 || cap_exp !== 32'd7 || cap_got !== 32'd8) begin errors++; $display("FAIL mis_capture got %0b/%h/%h exp 1/7/8", cap_vld, cap_exp, cap_got); end
      checks++; if (sticky_err !== 1'b1) begin errors++; $display("FAIL mis_sticky got %0b exp 1", sticky_err); end
      tick();
      checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL mis_pulse_width got %0b exp 0", err_pulse); end
      // Second mismatch (got 9): counted, capture keeps the first one.
      send(1'b0, 32'd1, 32'd2, 32'd4);
      idle(LAT - 1);
      respond(32'd9, 32'd0, 32'd0);
      checks++; if (mismatch_cnt !== 16'd2) begin errors++; $display("FAIL mis2_cnt got %0d exp 2", mismatch_cnt); end
      checks++; if (cap_exp !== 32'd7 || cap_got !== 32'd8) begin errors++; $display("FAIL mis2_capture got %h/%h exp 7/8", cap_exp, cap_got); end
   endtask

   task automatic test_a2b_wrap();
      do_clr();
      checks++; if ({check_cnt, mismatch_cnt, proto_cnt} !== 48'd0 || sticky_err !== 1'b0 || cap_vld !== 1'b0) begin errors++; $display("FAIL clr_state got %h/%0b/%0b exp 0/0/0", {check_cnt, mismatch_cnt, proto_cnt}, sticky_err, cap_vld); end
      // A2B: ref = FFFFFFFF+1+1 = 1; then a B2A sample right behind it (ref 3).
      send(1'b1, 32'hFFFF_FFFF, 32'd1, 32'd1);
      send(1'b0, 32'd3, 32'd0, 32'd0);
      idle(LAT - 2);
      respond(32'd3, 32'd2, 32'd0);      // xor 1, add 5
      checks++; if (check_cnt !== 16'd1 || mismatch_cnt !== 16'd0) begin errors++; $display("FAIL a2b_wrap got %0d/%0d exp 1/0", check_cnt, mismatch_cnt); end
      respond(32'd1, 32'd1, 32'd1);      // add 3, xor 1
      checks++; if (check_cnt !== 16'd2 || mismatch_cnt !== 16'd0) begin errors++; $display("FAIL mode_toggle got %0d/%0d exp 2/0", check_cnt, mismatch_cnt); end
      checks++; if (err_pulse !== 1'b0 || sticky_err !== 1'b0) begin errors++; $display("FAIL mode_toggle_err got %0b/%0b exp 0/0", err_pulse, sticky_err); end
   endtask

   task automatic test_protocol();
      do_clr();
      send(1'b0, 32'd1, 32'd2, 32'd4);
      idle(LAT - 2);
      respond(32'd5, 32'd1, 32'd1);      // one cycle early
      checks++; if (proto_cnt !== 16'd1 || err_pulse !== 1'b1) begin errors++; $display("FAIL proto_unexpected got %0d/%0b exp 1/1", proto_cnt, err_pulse); end
      tick();
      checks++; if (proto_cnt !== 16'd2 || check_cnt !== 16'd0) begin errors++; $display("FAIL proto_missing got %0d/%0d exp 2/0", proto_cnt, check_cnt); end
      checks++; if (sticky_err !== 1'b1 || cap_vld !== 1'b0) begin errors++; $display("FAIL proto_flags got %0b/%0b exp 1/0", sticky_err, cap_vld); end
   endtask

   task automatic test_clr_and_saturation();
      do_clr();
      send(1'b0, 32'd1, 32'd2, 32'd4);
      idle(LAT - 1);
      out_shares = {32'd2, 32'd1, 32'd5};
      out_vld = 1'b1;
      clr = 1'b1;
      tick();
      out_vld = 1'b0;
      clr = 1'b0;
      checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL clr_coinc_pulse got %0b exp 1", err_pulse); end
      checks++; if ({check_cnt, mismatch_cnt, proto_cnt} !== 48'd0 || cap_vld !== 1'b0 || sticky_err !== 1'b0) begin errors++; $display("FAIL clr_coinc_state got %h/%0b/%0b exp 0/0/0", {check_cnt, mismatch_cnt, proto_cnt}, cap_vld, sticky_err); end
      // 20 back-to-back mismatches: ref 1, got 2.
      for (int c = 0; c < 20 + LAT; c++) begin
         mode       = 1'b0;
         in_vld     = (c < 20);
         in_shares  = {32'd0, 32'd0, 32'd1};
         out_vld    = (c >= LAT) && (c < LAT + 20);
         out_shares = {32'd0, 32'd0, 32'd2};
         tick();
      end
      in_vld = 1'b0; out_vld = 1'b0;
      checks++; if (mismatch_cnt4 !== 4'd15 || check_cnt4 !== 4'd15) begin errors++; $display("FAIL sat4 got %0d/%0d exp 15/15", mismatch_cnt4, check_cnt4); end
      checks++; if (proto_cnt4 !== 4'd0 || cap_exp4 !== 32'd1 || cap_got4 !== 32'd2 || cap_vld4 !== 1'b1) begin errors++; $display("FAIL sat4_capture got %0d/%h/%h exp 0/1/2", proto_cnt4, cap_exp4, cap_got4); end
      checks++; if (mismatch_cnt !== 16'd20 || proto_cnt !== 16'd0) begin errors++; $display("FAIL sat16 got %0d/%0d exp 20/0", mismatch_cnt, proto_cnt); end
   endtask

   task automatic test_reset_midflight();
      for (int i = 0; i < 5; i++) send(1'b0, 32'd1, 32'd2, 32'd4);
      tick();
      rst_n = 1'b0;
      #1;
      checks++; if ({check_cnt, mismatch_cnt, proto_cnt} !== 48'd0 || sticky_err !== 1'b0 || err_pulse !== 1'b0) begin errors++; $display("FAIL midrst_outputs got %h/%0b/%0b exp 0", {check_cnt, mismatch_cnt, proto_cnt}, sticky_err, err_pulse); end
      checks++; if ({cap_vld, cap_exp, cap_got} !== 65'd0 || sticky_err4 !== 1'b0 || err_pulse4 !== 1'b0 || cap_vld4 !== 1'b0) begin errors++; $display("FAIL midrst_capture got %h exp 0", {cap_vld, cap_exp, cap_got}); end
      idle(2);
      rst_n = 1'b1;
      idle(LAT - 8);
      for (int i = 0; i < 5; i++) respond(32'd5, 32'd1, 32'd1);
      checks++; if (proto_cnt !== 16'd5 || check_cnt !== 16'd0 || mismatch_cnt !== 16'd0) begin errors++; $display("FAIL midrst_unexpected got %0d/%0d/%0d exp 5/0/0", proto_cnt, check_cnt, mismatch_cnt); end
      checks++; if (sticky_err !== 1'b1 || cap_vld !== 1'b0) begin errors++; $display("FAIL midrst_flags got %0b/%0b exp 1/0", sticky_err, cap_vld); end
   endtask

   initial begin
      test_reset();
      test_b2a_pass();
      test_b2a_mismatch();
      test_a2b_wrap();
      test_protocol();
      test_clr_and_saturation();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
